// File: rtl/food_placer.sv
// Food-placement controller: draws LFSR candidates, rejects walls and snake
// pieces (one piece compared per cycle), commits the first clean cell.
module food_placer #(
  parameter int GRID_WIDTH  = 32,
  parameter int GRID_HEIGHT = 24,
  parameter int NUM_PIECES  = 16,
  parameter int X_BITS      = 5,
  parameter int Y_BITS      = 5,
  parameter int MAX_TRIES   = 64,
  parameter int RESET_X     = 10,
  parameter int RESET_Y     = 5
) (
  input  logic                                Clock,
  input  logic                                ResetN,
  input  logic                                Request,
  input  logic                                SeedLoad,
  input  logic [15:0]                         Seed,
  input  logic [0:X_BITS*NUM_PIECES-1]        packSnakeX,
  input  logic [0:Y_BITS*NUM_PIECES-1]        packSnakeY,
  input  logic [$clog2(NUM_PIECES+1)-1:0]     SnakeLength,
  output logic [X_BITS-1:0]                   FoodX,
  output logic [Y_BITS-1:0]                   FoodY,
  output logic                                Busy,
  output logic                                Done,
  output logic                                Fail
);
  localparam int LW = $clog2(NUM_PIECES + 1);
  localparam int IW = (NUM_PIECES > 1) ? $clog2(NUM_PIECES) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [1:0] {IDLE, GEN, CHECK, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [X_BITS-1:0]   cand_x_q, cand_x_d, food_x_q, food_x_d;
  logic [Y_BITS-1:0]   cand_y_q, cand_y_d, food_y_q, food_y_d;
  logic [LW-1:0]       idx_q, idx_d, len_c;
  logic [TW-1:0]       tries_q, tries_d;
  logic                done_q, done_d, fail_q, fail_d;
  logic [X_BITS-1:0]   lfsr_x;
  logic [Y_BITS-1:0]   lfsr_y;
  logic [X_BITS-1:0]   body_x [NUM_PIECES];
  logic [Y_BITS-1:0]   body_y [NUM_PIECES];
  logic                in_range, hit, reject;

  // Bus is declared ascending but bit k of piece h sits at h*BITS+k, so
  // each coordinate is reassembled LSB-first.
  for (genvar h = 0; h < NUM_PIECES; h++) begin : g_unpack
    for (genvar k = 0; k < X_BITS; k++) begin : g_x
      assign body_x[h][k] = packSnakeX[h*X_BITS+k];
    end
    for (genvar k = 0; k < Y_BITS; k++) begin : g_y
      assign body_y[h][k] = packSnakeY[h*Y_BITS+k];
    end
  end

  always_comb begin
    len_c    = (SnakeLength > LW'(NUM_PIECES)) ? LW'(NUM_PIECES) : SnakeLength;
    lfsr_x   = lfsr_q[X_BITS-1:0];
    lfsr_y   = lfsr_q[X_BITS+Y_BITS-1:X_BITS];
    in_range = (lfsr_x != '0) && (lfsr_x <= X_BITS'(GRID_WIDTH - 2)) &&
               (lfsr_y != '0) && (lfsr_y <= Y_BITS'(GRID_HEIGHT - 2));
    hit      = (body_x[idx_q[IW-1:0]] == cand_x_q) && (body_y[idx_q[IW-1:0]] == cand_y_q);
  end

  always_comb begin
    if (SeedLoad)
      lfsr_d = (Seed == '0) ? LFSR_INIT : Seed;
    else
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tries_d  = tries_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    reject   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Request) begin
          state_d = GEN;
          tries_d = '0;
          idx_d   = '0;
        end
      end
      GEN: begin
        cand_x_d = lfsr_x;
        cand_y_d = lfsr_y;
        if (in_range) begin
          idx_d   = '0;
          state_d = (len_c == '0) ? COMMIT : CHECK;
        end else begin
          reject = 1'b1;
        end
      end
      CHECK: begin
        if (hit)
          reject = 1'b1;
        else if (idx_q == len_c - LW'(1))
          state_d = COMMIT;
        else
          idx_d = idx_q + LW'(1);
      end
      COMMIT: begin
        food_x_d = cand_x_q;
        food_y_d = cand_y_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Both rejection sources share one attempt budget.
    if (reject) begin
      if (tries_q == TW'(MAX_TRIES - 1)) begin
        state_d = IDLE;
        fail_d  = 1'b1;
      end else begin
        tries_d = tries_q + TW'(1);
        state_d = GEN;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_INIT;
      idx_q    <= '0;
      tries_q  <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      food_x_q <= X_BITS'(RESET_X);
      food_y_q <= Y_BITS'(RESET_Y);
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      idx_q    <= idx_d;
      tries_q  <= tries_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  assign FoodX = food_x_q;
  assign FoodY = food_y_q;
  assign Busy  = (state_q != IDLE);
  assign Done  = done_q;
  assign Fail  = fail_q;

endmodule
